// File: rtl/ready_handshake_responder.sv
// Responder side of the ready/readyp 4-phase handshake: after a programmable
// latency it pops a response word from a small FIFO and holds readyp until ready drops.
module ready_handshake_responder #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  parameter int LAT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ready,
  output logic                     readyp,
  output logic [DW-1:0]            rsp_data,
  input  logic [LAT_W-1:0]         latency,
  input  logic                     wr_en,
  input  logic [DW-1:0]            wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy,
  output logic                     abort,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    ACK   = 2'd2
  } state_e;

  state_e             state_q;
  logic [LAT_W-1:0]   cnt_q;
  logic               readyp_q;
  logic [DW-1:0]      rsp_data_q;
  logic               abort_q;
  logic               overflow_q;

  logic [DW-1:0]      mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;

  logic               push;
  logic               pop;

  // Full is judged on the registered count, so a write while full is dropped
  // even when the same edge pops an entry.
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign push  = wr_en && !full;
  assign pop   = (state_q == DELAY) && ready && (cnt_q == '0) && !empty;

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  // NOTE: FIFO storage has no reset; only pointers/count define validity, so
  // the array can map to plain RAM/flops without a reset network.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push)          wr_ptr_q   <= wr_ptr_q + AW'(1);
      if (pop)           rd_ptr_q   <= rd_ptr_q + AW'(1);
      if (wr_en && full) overflow_q <= 1'b1;
      count_q <= count_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      readyp_q   <= 1'b0;
      rsp_data_q <= '0;
      abort_q    <= 1'b0;
    end else begin
      abort_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (ready) begin
            state_q <= DELAY;
            cnt_q   <= latency;
          end
        end
        DELAY: begin
          if (!ready) begin
            state_q <= IDLE;
            abort_q <= 1'b1;
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - LAT_W'(1);
          end else if (pop) begin
            state_q    <= ACK;
            readyp_q   <= 1'b1;
            rsp_data_q <= mem_q[rd_ptr_q];
          end
          // An empty FIFO with an expired count stalls here until a word arrives.
        end
        ACK: begin
          if (!ready) begin
            state_q  <= IDLE;
            readyp_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          readyp_q <= 1'b0;
        end
      endcase
    end
  end

  assign readyp   = readyp_q;
  assign rsp_data = rsp_data_q;
  assign abort    = abort_q;
  assign overflow = overflow_q;
  assign count    = count_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_ready_handshake_responder.sv
// Directed bench for ready_handshake_responder: handshake timing, latency,
// empty stall, abort, FIFO full/overflow/wrap and asynchronous reset.
module tb_ready_handshake_responder;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int LAT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             ready;
  logic             readyp;
  logic [DW-1:0]    rsp_data;
  logic [LAT_W-1:0] latency;
  logic             wr_en;
  logic [DW-1:0]    wr_data;
  logic             full;
  logic             empty;
  logic [2:0]       count;
  logic             busy;
  logic             abort;
  logic             overflow;

  int checks   = 0;
  int failures = 0;

  ready_handshake_responder #(.DW(DW), .DEPTH(DEPTH), .LAT_W(LAT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ready    (ready),
    .readyp   (readyp),
    .rsp_data (rsp_data),
    .latency  (latency),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .busy     (busy),
    .abort    (abort),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; stimulus and sampling happen 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    ready = 1'b0;
    wr_en = 1'b0;
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic push_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    ready = 1'b0; wr_en = 1'b0; wr_data = '0; latency = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++; if (readyp !== 1'b0) begin failures++; $display("FAIL reset_readyp got=%b exp=0", readyp); end
    checks++; if (rsp_data !== 8'h00) begin failures++; $display("FAIL reset_rsp_data got=%h exp=00", rsp_data); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%b full=%b exp empty=1 full=0", empty, full); end
    checks++; if (busy !== 1'b0 || abort !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset_status busy=%b abort=%b overflow=%b exp all 0", busy, abort, overflow); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || readyp !== 1'b0) begin failures++; $display("FAIL reset_idle busy=%b readyp=%b exp 0/0", busy, readyp); end
  endtask

  task automatic test_basic();
    apply_reset();
    push_word(8'hA5);
    checks++; if (count !== 3'd1 || empty !== 1'b0) begin failures++; $display("FAIL basic_push count=%0d empty=%b exp 1/0", count, empty); end
    latency = 4'd2;
    ready   = 1'b1;
    tick();
    checks++; if (busy !== 1'b1 || readyp !== 1'b0) begin failures++; $display("FAIL basic_accept busy=%b readyp=%b exp 1/0", busy, readyp); end
    tick(); tick();
    checks++; if (readyp !== 1'b0) begin failures++; $display("FAIL basic_early readyp got=%b exp=0", readyp); end
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'hA5) begin failures++; $display("FAIL basic_ack readyp=%b rsp=%h exp 1/A5", readyp, rsp_data); end
    checks++; if (count !== 3'd0 || empty !== 1'b1) begin failures++; $display("FAIL basic_pop count=%0d empty=%b exp 0/1", count, empty); end
    tick(); tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'hA5) begin failures++; $display("FAIL basic_hold readyp=%b rsp=%h exp 1/A5", readyp, rsp_data); end
    ready = 1'b0;
    tick();
    checks++; if (readyp !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_release readyp=%b busy=%b exp 0/0", readyp, busy); end
    checks++; if (rsp_data !== 8'hA5) begin failures++; $display("FAIL basic_retain rsp=%h exp=A5", rsp_data); end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    push_word(8'h11);
    push_word(8'h22);
    latency = 4'd0;
    ready   = 1'b1;
    tick();
    checks++; if (readyp !== 1'b0) begin failures++; $display("FAIL b2b_lat0_early readyp got=%b exp=0", readyp); end
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h11 || count !== 3'd1) begin
      failures++; $display("FAIL b2b_first readyp=%b rsp=%h count=%0d exp 1/11/1", readyp, rsp_data, count); end
    ready = 1'b0;
    tick();
    checks++; if (readyp !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL b2b_drop readyp=%b busy=%b exp 0/0", readyp, busy); end
    ready = 1'b1;
    tick();
    checks++; if (readyp !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL b2b_reaccept readyp=%b busy=%b exp 0/1", readyp, busy); end
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h22 || empty !== 1'b1) begin
      failures++; $display("FAIL b2b_second readyp=%b rsp=%h empty=%b exp 1/22/1", readyp, rsp_data, empty); end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_empty_stall();
    apply_reset();
    latency = 4'd1;
    ready   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++; if (readyp !== 1'b0 || busy !== 1'b1) begin
        failures++; $display("FAIL stall_cycle%0d readyp=%b busy=%b exp 0/1", i, readyp, busy); end
    end
    push_word(8'h3C);
    checks++; if (readyp !== 1'b0 || count !== 3'd1) begin failures++; $display("FAIL stall_push readyp=%b count=%0d exp 0/1", readyp, count); end
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h3C || empty !== 1'b1) begin
      failures++; $display("FAIL stall_ack readyp=%b rsp=%h empty=%b exp 1/3C/1", readyp, rsp_data, empty); end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    apply_reset();
    push_word(8'h77);
    latency = 4'd5;
    ready   = 1'b1;
    tick(); tick();
    checks++; if (abort !== 1'b0) begin failures++; $display("FAIL abort_premature abort got=%b exp=0", abort); end
    ready = 1'b0;
    tick();
    checks++; if (abort !== 1'b1 || busy !== 1'b0 || readyp !== 1'b0) begin
      failures++; $display("FAIL abort_pulse abort=%b busy=%b readyp=%b exp 1/0/0", abort, busy, readyp); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL abort_no_pop count=%0d exp=1", count); end
    tick();
    checks++; if (abort !== 1'b0) begin failures++; $display("FAIL abort_width abort got=%b exp=0", abort); end
    // latency is changed mid-DELAY; the value captured at acceptance must win.
    latency = 4'd1;
    ready   = 1'b1;
    tick();
    latency = 4'd7;
    tick();
    checks++; if (readyp !== 1'b0) begin failures++; $display("FAIL abort_lat_early readyp got=%b exp=0", readyp); end
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h77) begin failures++; $display("FAIL abort_retry readyp=%b rsp=%h exp 1/77", readyp, rsp_data); end
    ready = 1'b0;
    tick();
  endtask

  task automatic test_full_overflow();
    logic [DW-1:0] exp_q [$];
    int lat;
    apply_reset();
    for (int i = 1; i <= 5; i++) begin
      push_word(DW'(i));
      if (i == 4) begin
        checks++; if (full !== 1'b1 || count !== 3'd4 || overflow !== 1'b0) begin
          failures++; $display("FAIL full_at4 full=%b count=%0d overflow=%b exp 1/4/0", full, count, overflow); end
      end
    end
    checks++; if (overflow !== 1'b1 || count !== 3'd4) begin failures++; $display("FAIL overflow_set overflow=%b count=%0d exp 1/4", overflow, count); end
    for (int i = 0; i < 4; i++) begin
      lat = (i == 0) ? 15 : 0;
      latency = LAT_W'(lat);
      ready   = 1'b1;
      tick();
      repeat (lat) tick();
      checks++; if (readyp !== 1'b0) begin failures++; $display("FAIL drain%0d_early readyp got=%b exp=0", i, readyp); end
      tick();
      checks++; if (readyp !== 1'b1 || rsp_data !== DW'(i + 1)) begin
        failures++; $display("FAIL drain%0d readyp=%b rsp=%h exp 1/%h", i, readyp, rsp_data, DW'(i + 1)); end
      ready = 1'b0;
      tick();
    end
    checks++; if (empty !== 1'b1 || overflow !== 1'b1) begin failures++; $display("FAIL drained empty=%b overflow=%b exp 1/1", empty, overflow); end
    // Second lap through the pointers, then a write while full on a pop edge.
    push_word(8'h10); push_word(8'h20); push_word(8'h30); push_word(8'h40);
    latency = 4'd0;
    ready   = 1'b1;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'hEE;
    tick();
    wr_en   = 1'b0;
    checks++; if (rsp_data !== 8'h10 || count !== 3'd3) begin failures++; $display("FAIL full_pop_drop rsp=%h count=%0d exp 10/3", rsp_data, count); end
    ready = 1'b0;
    tick();
    ready = 1'b1;
    tick();
    wr_en   = 1'b1;
    wr_data = 8'h50;
    tick();
    wr_en   = 1'b0;
    checks++; if (rsp_data !== 8'h20 || count !== 3'd3) begin failures++; $display("FAIL push_pop rsp=%h count=%0d exp 20/3", rsp_data, count); end
    ready = 1'b0;
    tick();
    exp_q = '{8'h30, 8'h40, 8'h50};
    foreach (exp_q[i]) begin
      ready = 1'b1;
      tick(); tick();
      checks++; if (readyp !== 1'b1 || rsp_data !== exp_q[i]) begin
        failures++; $display("FAIL wrap%0d readyp=%b rsp=%h exp 1/%h", i, readyp, rsp_data, exp_q[i]); end
      ready = 1'b0;
      tick();
    end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL wrap_empty empty got=%b exp=1", empty); end
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    for (int i = 0; i < 5; i++) push_word(8'h61 + DW'(i));
    latency = 4'd0;
    ready   = 1'b1;
    tick(); tick();
    ready = 1'b0;
    tick();
    ready = 1'b1;
    tick(); tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h62 || count !== 3'd2 || overflow !== 1'b1) begin
      failures++; $display("FAIL midrst_setup readyp=%b rsp=%h count=%0d ovf=%b exp 1/62/2/1", readyp, rsp_data, count, overflow); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (readyp !== 1'b0 || count !== 3'd0 || overflow !== 1'b0) begin
      failures++; $display("FAIL midrst_async readyp=%b count=%0d ovf=%b exp 0/0/0", readyp, count, overflow); end
    checks++; if (busy !== 1'b0 || empty !== 1'b1 || rsp_data !== 8'h00) begin
      failures++; $display("FAIL midrst_state busy=%b empty=%b rsp=%h exp 0/1/00", busy, empty, rsp_data); end
    ready = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    ready = 1'b1;
    tick(); tick(); tick();
    checks++; if (busy !== 1'b1 || readyp !== 1'b0) begin failures++; $display("FAIL midrst_stall busy=%b readyp=%b exp 1/0", busy, readyp); end
    push_word(8'h99);
    tick();
    checks++; if (readyp !== 1'b1 || rsp_data !== 8'h99) begin failures++; $display("FAIL midrst_resume readyp=%b rsp=%h exp 1/99", readyp, rsp_data); end
    ready = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_empty_stall();
    test_abort();
    test_full_overflow();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
